// File: rtl/field_tag_encoder.sv
// Protobuf per-field header encoder: emits the key varint, then the length varint
// for length-delimited fields, one byte per handshake, LSB group first.
module field_tag_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [28:0] in_field_id,
    input  logic [4:0]  in_field_type,
    input  logic [15:0] in_size,
    input  logic        in_nested,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        out_nested,
    output logic        err_type,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        LEN  = 2'd2
    } state_t;

    function automatic logic [2:0] wire_type_of(input logic [4:0] t);
        case (t)
            5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18: wire_type_of = 3'd0;
            5'd1, 5'd6, 5'd16:                                  wire_type_of = 3'd1;
            5'd9, 5'd11, 5'd12:                                 wire_type_of = 3'd2;
            5'd10:                                              wire_type_of = 3'd3;
            5'd2, 5'd7, 5'd15:                                  wire_type_of = 3'd5;
            default:                                            wire_type_of = 3'd7;
        endcase
    endfunction

    function automatic logic type_ok(input logic [4:0] t);
        type_ok = (t >= 5'd1) && (t <= 5'd18);
    endfunction

    // Continuation bit is set whenever anything remains above the low seven bits.
    function automatic logic [7:0] vbyte(input logic [31:0] v);
        vbyte = {(v[31:7] != 25'd0), v[6:0]};
    endfunction

    state_t      state_r, state_s;
    logic [31:0] rem_r, rem_s;
    logic [15:0] size_r, size_s;
    logic [2:0]  wt_r, wt_s;
    logic        out_valid_r, out_valid_s;
    logic [7:0]  out_byte_r, out_byte_s;
    logic        out_last_r, out_last_s;
    logic        out_nested_r, out_nested_s;
    logic        err_type_r, err_type_s;
    logic        accept_s, hs_s;
    logic [31:0] key_s;
    logic [2:0]  in_wt_s;
    logic [31:0] size_ext_s;

    assign in_ready   = (state_r == IDLE);
    assign busy       = (state_r != IDLE);
    assign out_valid  = out_valid_r;
    assign out_byte   = out_byte_r;
    assign out_last   = out_last_r;
    assign out_nested = out_nested_r;
    assign err_type   = err_type_r;

    // Next-state and next-output computation for the header FSM.
    always_comb begin
        state_s      = state_r;
        rem_s        = rem_r;
        size_s       = size_r;
        wt_s         = wt_r;
        out_valid_s  = out_valid_r;
        out_byte_s   = out_byte_r;
        out_last_s   = out_last_r;
        out_nested_s = out_nested_r;
        err_type_s   = 1'b0;
        accept_s     = in_valid && (state_r == IDLE);
        hs_s         = out_valid_r && out_ready;
        in_wt_s      = wire_type_of(in_field_type);
        key_s        = {in_field_id, in_wt_s};
        size_ext_s   = {16'd0, size_r};

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (!type_ok(in_field_type) || (in_field_id == 29'd0)) begin
                        err_type_s = 1'b1;
                    end else begin
                        state_s      = TAG;
                        rem_s        = key_s >> 5'd7;
                        size_s       = in_size;
                        wt_s         = in_wt_s;
                        out_valid_s  = 1'b1;
                        out_byte_s   = vbyte(key_s);
                        out_last_s   = (key_s[31:7] == 25'd0) && (in_wt_s != 3'd2);
                        out_nested_s = in_nested;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            TAG: begin
                if (hs_s) begin
                    if (!out_byte_r[7]) begin
                        if (wt_r == 3'd2) begin
                            state_s    = LEN;
                            out_byte_s = vbyte(size_ext_s);
                            rem_s      = size_ext_s >> 5'd7;
                            out_last_s = (size_r[15:7] == 9'd0);
                        end else begin
                            state_s     = IDLE;
                            out_valid_s = 1'b0;
                            out_last_s  = 1'b0;
                        end
                    end else begin
                        out_byte_s = vbyte(rem_r);
                        rem_s      = rem_r >> 5'd7;
                        out_last_s = (rem_r[31:7] == 25'd0) && (wt_r != 3'd2);
                    end
                end else begin
                    state_s = TAG;
                end
            end
            LEN: begin
                if (hs_s) begin
                    if (!out_byte_r[7]) begin
                        state_s     = IDLE;
                        out_valid_s = 1'b0;
                        out_last_s  = 1'b0;
                    end else begin
                        out_byte_s = vbyte(rem_r);
                        rem_s      = rem_r >> 5'd7;
                        out_last_s = (rem_r[31:7] == 25'd0);
                    end
                end else begin
                    state_s = LEN;
                end
            end
            default: begin
                state_s     = IDLE;
                out_valid_s = 1'b0;
                out_last_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any field in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            rem_r        <= 32'd0;
            size_r       <= 16'd0;
            wt_r         <= 3'd0;
            out_valid_r  <= 1'b0;
            out_byte_r   <= 8'd0;
            out_last_r   <= 1'b0;
            out_nested_r <= 1'b0;
            err_type_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            rem_r        <= rem_s;
            size_r       <= size_s;
            wt_r         <= wt_s;
            out_valid_r  <= out_valid_s;
            out_byte_r   <= out_byte_s;
            out_last_r   <= out_last_s;
            out_nested_r <= out_nested_s;
            err_type_r   <= err_type_s;
        end
    end

endmodule

// File: tb/tb_field_tag_encoder.sv
// Directed bench for field_tag_encoder: hand-computed header byte streams,
// rejects, backpressure and asynchronous reset mid-field.
module tb_field_tag_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [28:0] in_field_id;
    logic [4:0]  in_field_type;
    logic [15:0] in_size;
    logic        in_nested;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        out_nested;
    logic        err_type;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    field_tag_encoder dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_field_id   (in_field_id),
        .in_field_type (in_field_type),
        .in_size       (in_size),
        .in_nested     (in_nested),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_byte      (out_byte),
        .out_last      (out_last),
        .out_nested    (out_nested),
        .err_type      (err_type),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [28:0] id, input logic [4:0] t, input logic [15:0] sz, input logic nst);
        in_valid      = 1'b1;
        in_field_id   = id;
        in_field_type = t;
        in_size       = sz;
        in_nested     = nst;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_field_id = 29'd0; in_field_type = 5'd0; in_size = 16'd0; in_nested = 1'b0;
        #3;
        checks++;
        if ({in_ready, out_valid, out_byte, out_last, out_nested, err_type, busy} !== 14'b1_0_00000000_0_0_0_0) begin
            failures++;
            $display("FAIL reset_values: got rdy=%b v=%b b=%h l=%b n=%b e=%b busy=%b, expected 1 0 00 0 0 0 0",
                     in_ready, out_valid, out_byte, out_last, out_nested, err_type, busy);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_byte();
        offer(29'd1, 5'd5, 16'd0, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h08 || out_last !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_byte: got v=%b b=%h l=%b busy=%b expected v=1 b=08 l=1 busy=1", out_valid, out_byte, out_last, busy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_done: got v=%b busy=%b rdy=%b expected 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_length();
        logic [7:0] exp [5];
        int n;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                offer(29'd2, 5'd9, 16'd300, 1'b0);
                exp[0] = 8'h12; exp[1] = 8'hAC; exp[2] = 8'h02; n = 3;
            end else begin
                offer(29'd2, 5'd9, 16'd0, 1'b0);
                exp[0] = 8'h12; exp[1] = 8'h00; n = 2;
            end
            tick();
            in_valid = 1'b0;
            for (int i = 0; i < n; i++) begin
                checks++;
                if (out_valid !== 1'b1 || out_byte !== exp[i] || out_last !== (i == n - 1)) begin
                    failures++;
                    $display("FAIL length case%0d byte%0d: got v=%b b=%h l=%b expected v=1 b=%h l=%b",
                             c, i, out_valid, out_byte, out_last, exp[i], (i == n - 1));
                end
                tick();
            end
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL length case%0d end: got v=%b busy=%b expected 0 0", c, out_valid, busy);
            end
        end
    endtask

    task automatic test_long_keys();
        logic [7:0] exp [5];
        int n;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                offer(29'd16, 5'd1, 16'd0, 1'b0);
                exp[0] = 8'h81; exp[1] = 8'h01; n = 2;
            end else begin
                offer(29'h1FFFFFFF, 5'd7, 16'd0, 1'b0);
                exp[0] = 8'hFD; exp[1] = 8'hFF; exp[2] = 8'hFF; exp[3] = 8'hFF; exp[4] = 8'h0F; n = 5;
            end
            tick();
            in_valid = 1'b0;
            for (int i = 0; i < n; i++) begin
                checks++;
                if (out_valid !== 1'b1 || out_byte !== exp[i] || out_last !== (i == n - 1)) begin
                    failures++;
                    $display("FAIL key case%0d byte%0d: got v=%b b=%h l=%b expected v=1 b=%h l=%b",
                             c, i, out_valid, out_byte, out_last, exp[i], (i == n - 1));
                end
                tick();
            end
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL key case%0d end: got v=%b busy=%b expected 0 0", c, out_valid, busy);
            end
        end
    endtask

    task automatic test_rejects();
        offer(29'd1, 5'd0, 16'd0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) offer(29'd1, 5'd19, 16'd0, 1'b0);
            else if (k == 1) offer(29'd0, 5'd5, 16'd0, 1'b0);
            else in_valid = 1'b0;
            checks++;
            if (err_type !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reject%0d: got err=%b v=%b rdy=%b busy=%b expected 1 0 1 0", k, err_type, out_valid, in_ready, busy);
            end
            tick();
        end
        checks++;
        if (err_type !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reject_clear: got err=%b v=%b expected 0 0", err_type, out_valid);
        end
        offer(29'd1, 5'd8, 16'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h08 || out_last !== 1'b1 || err_type !== 1'b0) begin
            failures++;
            $display("FAIL after_reject: got v=%b b=%h l=%b err=%b expected 1 08 1 0", out_valid, out_byte, out_last, err_type);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        // per sampled cycle: out_ready driven, expected valid/byte/last/nested/in_ready
        logic       rdy  [7];
        logic       ev   [7];
        logic [7:0] eb   [7];
        logic       el   [7];
        logic       en   [7];
        logic       eir  [7];
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ev  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        eb  = '{8'h1A, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01, 8'h08};
        el  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        en  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        eir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        offer(29'd3, 5'd11, 16'd128, 1'b1);
        tick();
        offer(29'd1, 5'd5, 16'd0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            out_ready = rdy[i];
            if (i == 6) in_valid = 1'b0;
            checks++;
            if (out_valid !== ev[i] || (ev[i] && (out_byte !== eb[i] || out_last !== el[i] || out_nested !== en[i]))
                || in_ready !== eir[i]) begin
                failures++;
                $display("FAIL backpressure cyc%0d: got v=%b b=%h l=%b n=%b rdy=%b expected v=%b b=%h l=%b n=%b rdy=%b",
                         i, out_valid, out_byte, out_last, out_nested, in_ready, ev[i], eb[i], el[i], en[i], eir[i]);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_end: got v=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_field();
        offer(29'd2, 5'd9, 16'd300, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_byte !== 8'hAC || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: got v=%b b=%h expected 1 ac", out_valid, out_byte);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_byte, out_last, out_nested, err_type, busy} !== 14'b1_0_00000000_0_0_0_0) begin
            failures++;
            $display("FAIL mid_reset: got rdy=%b v=%b b=%h l=%b n=%b e=%b busy=%b expected 1 0 00 0 0 0 0",
                     in_ready, out_valid, out_byte, out_last, out_nested, err_type, busy);
        end
        #2;
        reset = 1'b0;
        tick();
        offer(29'd16, 5'd1, 16'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h81 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL post_reset0: got v=%b b=%h l=%b expected 1 81 0", out_valid, out_byte, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h01 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL post_reset1: got v=%b b=%h l=%b expected 1 01 1", out_valid, out_byte, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_end: got v=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_length();
        test_long_keys();
        test_rejects();
        test_back_to_back();
        test_reset_mid_field();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
